i2c_slave_core: RTL and testbench

Synthesizable I2C slave that sits directly downstream of the `i2c_top` master on the shared SDA/SCL bus, running on the I2C core clock. It replaces the behavioural slave model as the DUT-side target. It oversamples the bus, detects START/STOP, matches a 7-bit address, and ACKs and receives write bytes. On reads it shifts out bytes supplied by local logic. It reports received bytes and bus events as single-cycle pulses.

---
 rtl/i2c_slave_pkg.sv | 24 ++
 rtl/i2c_sync_filter.sv | 66 ++++++
 rtl/i2c_slave_core.sv | 261 ++++++++++++++++++++++++++
 tb/tb_i2c_slave_core.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_slave_pkg.sv
// -----------------------------------------------------------------------------
// i2c_slave_pkg
// Shared types and widths for the I2C slave core.
//   i2c_slv_state_e : slave protocol state machine encoding
//   I2C_ADDR_W      : width of the 7-bit slave address
//   I2C_BYTE_W      : width of one bus byte
// -----------------------------------------------------------------------------
package i2c_slave_pkg;

    localparam int I2C_ADDR_W = 7;
    localparam int I2C_BYTE_W = 8;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ADDR     = 3'd1,
        ADDR_ACK = 3'd2,
        RX       = 3'd3,
        RX_ACK   = 3'd4,
        TX       = 3'd5,
        TX_ACK   = 3'd6,
        IGNORE   = 3'd7
    } i2c_slv_state_e;

endpackage

// File: rtl/i2c_sync_filter.sv
// -----------------------------------------------------------------------------
// i2c_sync_filter
// Conditions one raw bus line: SYNC_STAGES-deep synchronizer followed by a
// glitch filter. The filtered value flips only after FILTER_LEN consecutive
// samples that disagree with it. A one-cycle-delayed copy of the filtered
// value is also provided so the parent can decode edges.
// Ports:
//   clk_i   in  core clock
//   rst_i   in  asynchronous active-high reset (line state resets to 1)
//   line_i  in  raw, asynchronous bus line
//   filt_o  out filtered line value
//   prev_o  out filtered line value from the previous cycle
// -----------------------------------------------------------------------------
module i2c_sync_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 3
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic line_i,
    output logic filt_o,
    output logic prev_o
);

    localparam logic [2:0] CNT_MAX = 3'(FILTER_LEN - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   filt_q, filt_d;
    logic                   prev_q;
    logic [2:0]             cnt_q, cnt_d;
    logic                   samp;

    assign samp = sync_q[SYNC_STAGES-1];

    // Count disagreeing samples; any agreeing sample restarts the count,
    // so a pulse shorter than FILTER_LEN never reaches the output.
    always_comb begin
        filt_d = filt_q;
        cnt_d  = 3'd0;
        if (samp != filt_q) begin
            if (cnt_q == CNT_MAX) begin
                filt_d = samp;
            end else begin
                cnt_d = cnt_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '1;
            filt_q <= 1'b1;
            prev_q <= 1'b1;
            cnt_q  <= 3'd0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], line_i};
            filt_q <= filt_d;
            prev_q <= filt_q;
            cnt_q  <= cnt_d;
        end
    end

    assign filt_o = filt_q;
    assign prev_o = prev_q;

endmodule

// File: rtl/i2c_slave_core.sv
// -----------------------------------------------------------------------------
// i2c_slave_core
// Synthesizable I2C slave on the I2C core clock. Oversamples SCL/SDA,
// detects START/STOP, matches a 7-bit address, ACKs and receives write
// bytes, and shifts out locally supplied bytes on reads.
// Ports:
//   i2c_core_clk_i  in  core clock (only clock)
//   i2c_core_rst_i  in  asynchronous active-high reset
//   scl_i, sda_i    in  raw bus lines
//   sda_oe_o        out 1 = pull SDA low
//   slave_addr_i    in  own 7-bit address
//   tx_data_i       in  byte to send on the next read byte
//   tx_data_req_o   out 1-cycle pulse when tx_data_i is captured
//   rx_data_o       out last received write byte
//   rx_valid_o      out 1-cycle pulse when rx_data_o updates
//   start_o/stop_o  out 1-cycle pulses on START (incl. repeated) / STOP
//   busy_o          out high from START to STOP
//   dbg_state_o     out current protocol state, for debug/checkers
// -----------------------------------------------------------------------------
module i2c_slave_core
    import i2c_slave_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 3
) (
    input  logic                  i2c_core_clk_i,
    input  logic                  i2c_core_rst_i,
    input  logic                  scl_i,
    input  logic                  sda_i,
    output logic                  sda_oe_o,
    input  logic [I2C_ADDR_W-1:0] slave_addr_i,
    input  logic [I2C_BYTE_W-1:0] tx_data_i,
    output logic                  tx_data_req_o,
    output logic [I2C_BYTE_W-1:0] rx_data_o,
    output logic                  rx_valid_o,
    output logic                  start_o,
    output logic                  stop_o,
    output logic                  busy_o,
    output i2c_slv_state_e        dbg_state_o
);

    // ---------------------------------------------------------------- lines
    logic scl_f, scl_p, sda_f, sda_p;

    i2c_sync_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_LEN  (FILTER_LEN)
    ) u_scl_filt (
        .clk_i  (i2c_core_clk_i),
        .rst_i  (i2c_core_rst_i),
        .line_i (scl_i),
        .filt_o (scl_f),
        .prev_o (scl_p)
    );

    i2c_sync_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_LEN  (FILTER_LEN)
    ) u_sda_filt (
        .clk_i  (i2c_core_clk_i),
        .rst_i  (i2c_core_rst_i),
        .line_i (sda_i),
        .filt_o (sda_f),
        .prev_o (sda_p)
    );

    // --------------------------------------------------------------- events
    logic scl_rise, scl_fall, start_evt, stop_evt;

    assign scl_rise  =  scl_f & ~scl_p;
    assign scl_fall  = ~scl_f &  scl_p;
    // SCL must be high on both sides of the SDA edge to count as START/STOP.
    assign start_evt =  scl_f &  scl_p &  sda_p & ~sda_f;
    assign stop_evt  =  scl_f &  scl_p & ~sda_p &  sda_f;

    // ------------------------------------------------------------ registers
    i2c_slv_state_e        state_q, state_d;
    logic [2:0]            bit_cnt_q, bit_cnt_d;
    logic [I2C_BYTE_W-1:0] shift_q, shift_d;
    logic                  byte_done_q, byte_done_d; // 8th bit seen, waiting for the fall
    logic                  rw_q, rw_d;
    logic                  ack_q, ack_d;             // master ACK sampled in TX_ACK
    logic                  sda_oe_q, sda_oe_d;
    logic [I2C_BYTE_W-1:0] rx_data_q, rx_data_d;
    logic                  rx_valid_q, rx_valid_d;
    logic                  tx_req_q, tx_req_d;
    logic                  start_q, start_d;
    logic                  stop_q, stop_d;
    logic                  busy_q, busy_d;

    // ------------------------------------------------------ next-state logic
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        byte_done_d = byte_done_q;
        rw_d        = rw_q;
        ack_d       = ack_q;
        sda_oe_d    = sda_oe_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        tx_req_d    = 1'b0;
        start_d     = start_evt;
        stop_d      = stop_evt;
        busy_d      = busy_q;

        if (stop_evt) begin
            // STOP wins over anything else in the same cycle.
            state_d     = IDLE;
            sda_oe_d    = 1'b0;
            byte_done_d = 1'b0;
            busy_d      = 1'b0;
        end else if (start_evt) begin
            state_d     = ADDR;
            bit_cnt_d   = 3'd0;
            shift_d     = '0;
            sda_oe_d    = 1'b0;
            byte_done_d = 1'b0;
            busy_d      = 1'b1;
        end else begin
            case (state_q)
                ADDR: begin
                    if (scl_rise && !byte_done_q) begin
                        shift_d   = {shift_q[6:0], sda_f};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            // shift_q[6:0] becomes the address field once sda_f
                            // (the R/W bit) is shifted in.
                            if (shift_q[6:0] == slave_addr_i) begin
                                byte_done_d = 1'b1;
                                rw_d        = sda_f;
                            end else begin
                                state_d = IGNORE;
                            end
                        end
                    end else if (scl_fall && byte_done_q) begin
                        sda_oe_d    = 1'b1;
                        byte_done_d = 1'b0;
                        state_d     = ADDR_ACK;
                    end
                end

                ADDR_ACK: begin
                    if (scl_fall) begin
                        bit_cnt_d = 3'd0;
                        if (!rw_q) begin
                            sda_oe_d = 1'b0;
                            state_d  = RX;
                        end else begin
                            shift_d  = tx_data_i;
                            tx_req_d = 1'b1;
                            sda_oe_d = ~tx_data_i[7];
                            state_d  = TX;
                        end
                    end
                end

                RX: begin
                    if (scl_rise && !byte_done_q) begin
                        shift_d   = {shift_q[6:0], sda_f};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            rx_data_d   = {shift_q[6:0], sda_f};
                            rx_valid_d  = 1'b1;
                            byte_done_d = 1'b1;
                        end
                    end else if (scl_fall && byte_done_q) begin
                        sda_oe_d    = 1'b1;
                        byte_done_d = 1'b0;
                        state_d     = RX_ACK;
                    end
                end

                RX_ACK: begin
                    if (scl_fall) begin
                        sda_oe_d  = 1'b0;
                        bit_cnt_d = 3'd0;
                        state_d   = RX;
                    end
                end

                TX: begin
                    if (scl_fall) begin
                        if (bit_cnt_q == 3'd7) begin
                            sda_oe_d = 1'b0;
                            state_d  = TX_ACK;
                        end else begin
                            // Rotate so the next bit to present sits in bit 7.
                            shift_d   = {shift_q[6:0], shift_q[7]};
                            sda_oe_d  = ~shift_q[6];
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end
                end

                TX_ACK: begin
                    if (scl_rise) begin
                        ack_d = sda_f;
                    end else if (scl_fall) begin
                        if (!ack_q) begin
                            shift_d   = tx_data_i;
                            tx_req_d  = 1'b1;
                            sda_oe_d  = ~tx_data_i[7];
                            bit_cnt_d = 3'd0;
                            state_d   = TX;
                        end else begin
                            state_d = IGNORE;
                        end
                    end
                end

                default: begin
                    // IDLE and IGNORE only react to START/STOP above.
                end
            endcase
        end
    end

    // ------------------------------------------------------- state register
    always_ff @(posedge i2c_core_clk_i or posedge i2c_core_rst_i) begin
        if (i2c_core_rst_i) begin
            state_q     <= IDLE;
            bit_cnt_q   <= 3'd0;
            shift_q     <= '0;
            byte_done_q <= 1'b0;
            rw_q        <= 1'b0;
            ack_q       <= 1'b1;
            sda_oe_q    <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            tx_req_q    <= 1'b0;
            start_q     <= 1'b0;
            stop_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            byte_done_q <= byte_done_d;
            rw_q        <= rw_d;
            ack_q       <= ack_d;
            sda_oe_q    <= sda_oe_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            tx_req_q    <= tx_req_d;
            start_q     <= start_d;
            stop_q      <= stop_d;
            busy_q      <= busy_d;
        end
    end

    assign sda_oe_o      = sda_oe_q;
    assign tx_data_req_o = tx_req_q;
    assign rx_data_o     = rx_data_q;
    assign rx_valid_o    = rx_valid_q;
    assign start_o       = start_q;
    assign stop_o        = stop_q;
    assign busy_o        = busy_q;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_i2c_slave_core.sv
// -----------------------------------------------------------------------------
// tb_i2c_slave_core
// Directed bench: a task-level I2C master drives an open-drain bus model
// against i2c_slave_core; each scenario task checks its own results.
// -----------------------------------------------------------------------------
module tb_i2c_slave_core;
    import i2c_slave_pkg::*;

    localparam int HALF = 20;  // cycles per SCL phase

    // ------------------------------------------------ clock / reset / bus
    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           scl_m = 1'b1;
    logic           sda_m = 1'b1;
    logic [6:0]     slave_addr = 7'h50;
    logic [7:0]     tx_data = 8'h00;
    logic           sda_oe;
    logic           tx_req;
    logic [7:0]     rx_data;
    logic           rx_valid;
    logic           start_p;
    logic           stop_p;
    logic           busy;
    i2c_slv_state_e dbg_state;
    logic           sda_bus;

    always #5 clk = ~clk;

    // Open-drain wired-AND of master and slave.
    assign sda_bus = sda_m & ~sda_oe;

    i2c_slave_core dut (
        .i2c_core_clk_i (clk),
        .i2c_core_rst_i (rst),
        .scl_i          (scl_m),
        .sda_i          (sda_bus),
        .sda_oe_o       (sda_oe),
        .slave_addr_i   (slave_addr),
        .tx_data_i      (tx_data),
        .tx_data_req_o  (tx_req),
        .rx_data_o      (rx_data),
        .rx_valid_o     (rx_valid),
        .start_o        (start_p),
        .stop_o         (stop_p),
        .busy_o         (busy),
        .dbg_state_o    (dbg_state)
    );

    // --------------------------------------------------- event monitor
    int         n_rx = 0, n_start = 0, n_stop = 0, n_req = 0, n_oe = 0;
    logic [7:0] rx_log[$];

    always @(negedge clk) begin
        if (rx_valid) begin
            n_rx++;
            rx_log.push_back(rx_data);
        end
        if (start_p) n_start++;
        if (stop_p)  n_stop++;
        if (tx_req)  n_req++;
        if (sda_oe)  n_oe++;
    end

    // ------------------------------------------------------- scoreboard
    int         tests_run = 0;
    int         tests_failed = 0;
    logic [7:0] exp_q[$];

    // --------------------------------------------------- driver tasks
    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Works from idle (both high) and as a repeated START (SCL low).
    task automatic bus_start();
        wait_cyc(4);  sda_m = 1'b1;
        wait_cyc(HALF); scl_m = 1'b1;
        wait_cyc(HALF); sda_m = 1'b0;
        wait_cyc(HALF); scl_m = 1'b0;
    endtask

    task automatic bus_stop();
        wait_cyc(4);  sda_m = 1'b0;
        wait_cyc(HALF); scl_m = 1'b1;
        wait_cyc(HALF); sda_m = 1'b1;
        wait_cyc(HALF);
    endtask

    // One master-driven bit; glitch=1 adds sub-filter pulses on both lines.
    task automatic send_bit(input logic b, input logic glitch);
        wait_cyc(4); sda_m = b;
        if (glitch) begin
            wait_cyc(6);  scl_m = 1'b1;
            wait_cyc(2);  scl_m = 1'b0;          // 2-cycle SCL high pulse
            wait_cyc(HALF - 8);
        end else begin
            wait_cyc(HALF);
        end
        scl_m = 1'b1;
        if (glitch) begin
            wait_cyc(6);  sda_m = ~b;
            wait_cyc(1);  sda_m = b;             // 1-cycle SDA pulse, SCL high
            wait_cyc(5);  scl_m = 1'b0;
            wait_cyc(1);  scl_m = 1'b1;          // 1-cycle SCL low pulse
            wait_cyc(HALF - 13);
        end else begin
            wait_cyc(HALF);
        end
        scl_m = 1'b0;
    endtask

    task automatic read_bit(output logic b);
        wait_cyc(4); sda_m = 1'b1;
        wait_cyc(HALF); scl_m = 1'b1;
        wait_cyc(HALF / 2); b = sda_bus;
        wait_cyc(HALF / 2); scl_m = 1'b0;
    endtask

    task automatic write_byte(input logic [7:0] d, input logic glitch, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(d[i], glitch && (i == 4));
        read_bit(ack);
    endtask

    task automatic read_byte(output logic [7:0] d, input logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            d[i] = b;
        end
        send_bit(ack, 1'b0);
    endtask

    // ------------------------------------------------------- scenarios
    task automatic test_reset();
        rst = 1'b1;
        wait_cyc(3);
        tests_run++; if (sda_oe !== 1'b0) begin tests_failed++; $display("FAIL reset_sda_oe got=%b exp=0", sda_oe); end
        tests_run++; if (rx_data !== 8'h00) begin tests_failed++; $display("FAIL reset_rx_data got=%h exp=00", rx_data); end
        tests_run++; if ({rx_valid, tx_req, start_p, stop_p, busy} !== 5'b0) begin
            tests_failed++; $display("FAIL reset_pulses got=%b exp=00000", {rx_valid, tx_req, start_p, stop_p, busy});
        end
        tests_run++; if (dbg_state !== IDLE) begin tests_failed++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, IDLE); end
        rst = 1'b0;
        wait_cyc(10);
    endtask

    task automatic test_write();
        int         s_rx = n_rx, s_start = n_start, s_stop = n_stop, idx = rx_log.size();
        logic       ack;
        logic [7:0] exp;
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h3C);
        bus_start();
        write_byte({7'h50, 1'b0}, 1'b0, ack);
        tests_run++; if (ack !== 1'b0) begin tests_failed++; $display("FAIL wr_addr_ack got=%b exp=0", ack); end
        write_byte(8'hA5, 1'b0, ack);
        tests_run++; if (ack !== 1'b0) begin tests_failed++; $display("FAIL wr_d0_ack got=%b exp=0", ack); end
        write_byte(8'h3C, 1'b0, ack);
        tests_run++; if (ack !== 1'b0) begin tests_failed++; $display("FAIL wr_d1_ack got=%b exp=0", ack); end
        tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL wr_busy_mid got=%b exp=1", busy); end
        bus_stop();
        tests_run++; if (n_rx - s_rx != 2) begin tests_failed++; $display("FAIL wr_rx_count got=%0d exp=2", n_rx - s_rx); end
        for (int i = 0; i < 2; i++) begin
            exp = exp_q.pop_front();
            tests_run++;
            if (rx_log.size() <= idx + i) begin
                tests_failed++; $display("FAIL wr_rx_byte%0d missing exp=%h", i, exp);
            end else if (rx_log[idx + i] !== exp) begin
                tests_failed++; $display("FAIL wr_rx_byte%0d got=%h exp=%h", i, rx_log[idx + i], exp);
            end
        end
        tests_run++; if (rx_data !== 8'h3C) begin tests_failed++; $display("FAIL wr_rx_hold got=%h exp=3c", rx_data); end
        tests_run++; if (n_start - s_start != 1) begin tests_failed++; $display("FAIL wr_start_count got=%0d exp=1", n_start - s_start); end
        tests_run++; if (n_stop - s_stop != 1) begin tests_failed++; $display("FAIL wr_stop_count got=%0d exp=1", n_stop - s_stop); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL wr_busy_end got=%b exp=0", busy); end
    endtask

    task automatic test_addr_mismatch();
        int   s_rx = n_rx, s_oe = n_oe;
        logic ack;
        bus_start();
        write_byte({7'h51, 1'b0}, 1'b0, ack);
        tests_run++; if (ack !== 1'b1) begin tests_failed++; $display("FAIL nm_addr_ack got=%b exp=1", ack); end
        write_byte(8'h00, 1'b0, ack);
        tests_run++; if (ack !== 1'b1) begin tests_failed++; $display("FAIL nm_data_ack got=%b exp=1", ack); end
        tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL nm_busy_mid got=%b exp=1", busy); end
        bus_stop();
        tests_run++; if (n_oe - s_oe != 0) begin tests_failed++; $display("FAIL nm_sda_oe_cycles got=%0d exp=0", n_oe - s_oe); end
        tests_run++; if (n_rx - s_rx != 0) begin tests_failed++; $display("FAIL nm_rx_count got=%0d exp=0", n_rx - s_rx); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL nm_busy_end got=%b exp=0", busy); end
    endtask

    task automatic test_read();
        int         s_req = n_req;
        logic       ack;
        logic [7:0] d0, d1;
        tx_data = 8'hC3;
        bus_start();
        write_byte({7'h50, 1'b1}, 1'b0, ack);
        tests_run++; if (ack !== 1'b0) begin tests_failed++; $display("FAIL rd_addr_ack got=%b exp=0", ack); end
        wait_cyc(10);
        tests_run++; if (n_req - s_req != 1) begin tests_failed++; $display("FAIL rd_req_first got=%0d exp=1", n_req - s_req); end
        tx_data = 8'h5A;
        read_byte(d0, 1'b0);
        read_byte(d1, 1'b1);
        tests_run++; if (d0 !== 8'hC3) begin tests_failed++; $display("FAIL rd_byte0 got=%h exp=c3", d0); end
        tests_run++; if (d1 !== 8'h5A) begin tests_failed++; $display("FAIL rd_byte1 got=%h exp=5a", d1); end
        wait_cyc(10);
        tests_run++; if (sda_oe !== 1'b0) begin tests_failed++; $display("FAIL rd_release_after_nack got=%b exp=0", sda_oe); end
        tests_run++; if (dbg_state !== IGNORE) begin tests_failed++; $display("FAIL rd_state_after_nack got=%0d exp=%0d", dbg_state, IGNORE); end
        bus_stop();
        tests_run++; if (n_req - s_req != 2) begin tests_failed++; $display("FAIL rd_req_count got=%0d exp=2", n_req - s_req); end
    endtask

    task automatic test_repeated_start();
        int         s_start = n_start, s_stop = n_stop;
        logic       ack;
        logic [7:0] d;
        bus_start();
        write_byte({7'h50, 1'b0}, 1'b0, ack);
        write_byte(8'h11, 1'b0, ack);
        tests_run++; if (ack !== 1'b0) begin tests_failed++; $display("FAIL rs_wr_ack got=%b exp=0", ack); end
        tx_data = 8'h9B;
        bus_start();
        tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL rs_busy_after_rstart got=%b exp=1", busy); end
        tests_run++; if (n_stop - s_stop != 0) begin tests_failed++; $display("FAIL rs_stop_before_end got=%0d exp=0", n_stop - s_stop); end
        write_byte({7'h50, 1'b1}, 1'b0, ack);
        tests_run++; if (ack !== 1'b0) begin tests_failed++; $display("FAIL rs_rd_addr_ack got=%b exp=0", ack); end
        read_byte(d, 1'b1);
        tests_run++; if (d !== 8'h9B) begin tests_failed++; $display("FAIL rs_rd_byte got=%h exp=9b", d); end
        tests_run++; if (n_start - s_start != 2) begin tests_failed++; $display("FAIL rs_start_count got=%0d exp=2", n_start - s_start); end
        tests_run++; if (rx_data !== 8'h11) begin tests_failed++; $display("FAIL rs_rx_data got=%h exp=11", rx_data); end
        bus_stop();
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL rs_busy_end got=%b exp=0", busy); end
    endtask

    task automatic test_glitch();
        int   s_rx = n_rx, s_start = n_start, s_stop = n_stop;
        logic ack;
        bus_start();
        write_byte({7'h50, 1'b0}, 1'b1, ack);
        tests_run++; if (ack !== 1'b0) begin tests_failed++; $display("FAIL gl_addr_ack got=%b exp=0", ack); end
        write_byte(8'h6B, 1'b1, ack);
        tests_run++; if (ack !== 1'b0) begin tests_failed++; $display("FAIL gl_data_ack got=%b exp=0", ack); end
        bus_stop();
        tests_run++; if (n_rx - s_rx != 1) begin tests_failed++; $display("FAIL gl_rx_count got=%0d exp=1", n_rx - s_rx); end
        tests_run++; if (rx_data !== 8'h6B) begin tests_failed++; $display("FAIL gl_rx_data got=%h exp=6b", rx_data); end
        tests_run++; if (n_start - s_start != 1) begin tests_failed++; $display("FAIL gl_start_count got=%0d exp=1", n_start - s_start); end
        tests_run++; if (n_stop - s_stop != 1) begin tests_failed++; $display("FAIL gl_stop_count got=%0d exp=1", n_stop - s_stop); end
    endtask

    task automatic test_reset_mid_read();
        int   s_rx;
        logic ack, b;
        tx_data = 8'hE0;  // bit 4 (4th bit on the wire) is 0, so SDA is pulled
        bus_start();
        write_byte({7'h50, 1'b1}, 1'b0, ack);
        for (int i = 0; i < 3; i++) read_bit(b);
        wait_cyc(10);
        tests_run++; if (sda_oe !== 1'b1) begin tests_failed++; $display("FAIL mr_driving_bit4 got=%b exp=1", sda_oe); end
        rst = 1'b1;
        #1;
        tests_run++; if (sda_oe !== 1'b0) begin tests_failed++; $display("FAIL mr_sda_oe_async got=%b exp=0", sda_oe); end
        tests_run++; if (dbg_state !== IDLE) begin tests_failed++; $display("FAIL mr_state got=%0d exp=%0d", dbg_state, IDLE); end
        wait_cyc(3);
        rst = 1'b0;
        sda_m = 1'b1;
        wait_cyc(HALF); scl_m = 1'b1;
        wait_cyc(HALF);
        s_rx = n_rx;
        bus_start();
        write_byte({7'h50, 1'b0}, 1'b0, ack);
        tests_run++; if (ack !== 1'b0) begin tests_failed++; $display("FAIL mr_addr_ack got=%b exp=0", ack); end
        write_byte(8'h77, 1'b0, ack);
        bus_stop();
        tests_run++; if (n_rx - s_rx != 1) begin tests_failed++; $display("FAIL mr_rx_count got=%0d exp=1", n_rx - s_rx); end
        tests_run++; if (rx_data !== 8'h77) begin tests_failed++; $display("FAIL mr_rx_data got=%h exp=77", rx_data); end
    endtask

    // ------------------------------------------------------------ main
    initial begin
        test_reset();
        test_write();
        test_addr_mismatch();
        test_read();
        test_repeated_start();
        test_glitch();
        test_reset_mid_read();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
